// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG AXI4-Lite FIFO peripheral.
// Contents: register word offsets, CTRL/STATUS bit positions, the LFSR
// polynomial and lane decorrelation constant, the AXI response encoding,
// and small helpers for LFSR stepping, lane seeding and byte-strobe merging.
package trng_pkg;

    // Word offsets (byte address >> 2).
    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_SEED   = 1;
    localparam int unsigned REG_STATUS = 2;
    localparam int unsigned REG_DATA   = 3;
    localparam int unsigned REG_THRESH = 4;

    // CTRL bits.
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_FLUSH  = 1;
    localparam int unsigned CTRL_CLR_UF = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;

    // STATUS bits ([7:0] is the FIFO level).
    localparam int unsigned STAT_EMPTY     = 16;
    localparam int unsigned STAT_FULL      = 17;
    localparam int unsigned STAT_UNDERFLOW = 18;

    localparam logic [31:0] LFSR_POLY   = 32'h80200003;
    localparam logic [31:0] LANE_GOLDEN = 32'h9E3779B9;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    // Right-shifting Galois step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // Each lane gets a distinct starting point derived from the common seed.
    function automatic logic [31:0] lane_seed(input logic [31:0] seed, input int unsigned k);
        return seed ^ (k * LANE_GOLDEN);
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_value,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] r;
        r = old_value;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/trng_lfsr_lane.sv
// One 32-bit Galois LFSR lane.
// Ports: clk/rst (async active-high), load + load_value (reseed, has
// priority), step (advance one state), next_state (combinational successor
// of the current state, used both for stepping and for the output word).
module trng_lfsr_lane
    import trng_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        step,
    output logic [31:0] next_state
);

    logic [31:0] state;

    assign next_state = lfsr_step(state);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       state <= RESET_VALUE;
        else if (load) state <= load_value;
        else if (step) state <= next_state;
    end

endmodule

// File: rtl/trng_axil_fifo.sv
// TRNG AXI4-Lite slave: NUM_LFSR XOR-combined LFSR lanes feed a FIFO that is
// drained by reads of the DATA register.
// Ports: s00_axi_* is a standard AXI4-Lite slave (aclk, async active-high
// areset, AW/W/B write channels, AR/R read channels).
// Build option: define TRNG_IRQ_EN to add the irq output, the THRESH register
// at 0x10 and CTRL bit3 IRQ_EN.
module trng_axil_fifo
    import trng_pkg::*;
#(
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter int          FIFO_DEPTH         = 8,
    parameter int          NUM_LFSR           = 2,
    parameter logic [31:0] DEFAULT_SEED       = 32'hACE12024
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic                          s00_axi_awvalid,
    output logic                          s00_axi_awready,
    input  logic [31:0]                   s00_axi_wdata,
    input  logic [3:0]                    s00_axi_wstrb,
    input  logic                          s00_axi_wvalid,
    output logic                          s00_axi_wready,
    output logic [1:0]                    s00_axi_bresp,
    output logic                          s00_axi_bvalid,
    input  logic                          s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [31:0]                   s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready
`ifdef TRNG_IRQ_EN
    ,
    output logic                          irq
`endif
);

    localparam int AIDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    logic [AIDX_W-1:0] widx, ridx;
    logic              wr_en, rd_en;
    logic              ctrl_en, underflow;
    logic [31:0]       seed_q, seed_merged, seed_new, gen_word, rd_word;
    logic              ctrl_wr, seed_wr, flush, clr_uf;
    logic              pop_req, pop, underflow_evt, gen;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [7:0]        level8;
    logic              empty, full;
    logic [31:0]       lane_next [NUM_LFSR];
`ifdef TRNG_IRQ_EN
    logic              irq_en;
    logic [7:0]        thresh;
`endif

    // Word-aligned decode; the byte-lane bits never select a register.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign widx  = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ridx  = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_en = s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_en = s00_axi_arready & s00_axi_arvalid;

    assign ctrl_wr = wr_en && (widx == AIDX_W'(REG_CTRL)) && s00_axi_wstrb[0];
    assign seed_wr = wr_en && (widx == AIDX_W'(REG_SEED));
    assign flush   = ctrl_wr && s00_axi_wdata[CTRL_FLUSH];
    assign clr_uf  = ctrl_wr && s00_axi_wdata[CTRL_CLR_UF];

    // A zero seed would lock a lane at zero forever, so it is replaced.
    assign seed_merged = apply_wstrb(seed_q, s00_axi_wdata, s00_axi_wstrb);
    assign seed_new    = (seed_merged == '0) ? DEFAULT_SEED : seed_merged;

    assign level8        = 8'(level);
    assign empty         = (level == '0);
    assign full          = (level == LVL_W'(FIFO_DEPTH));
    assign pop_req       = rd_en && (ridx == AIDX_W'(REG_DATA));
    assign pop           = pop_req && !empty;
    assign underflow_evt = pop_req && empty;
    // A reseed cycle loads the lanes instead of producing a word.
    assign gen           = ctrl_en && !full && !seed_wr;

    for (genvar k = 0; k < NUM_LFSR; k++) begin : g_lane
        trng_lfsr_lane #(
            .RESET_VALUE(lane_seed(DEFAULT_SEED, k))
        ) u_lane (
            .clk       (s00_axi_aclk),
            .rst       (s00_axi_areset),
            .load      (seed_wr),
            .load_value(lane_seed(seed_new, k)),
            .step      (gen),
            .next_state(lane_next[k])
        );
    end

    always_comb begin
        gen_word = '0;
        for (int k = 0; k < NUM_LFSR; k++) gen_word ^= lane_next[k];
    end

    // NOTE: the storage array carries no reset; level/pointers define validity.
    always_ff @(posedge s00_axi_aclk) begin
        if (gen) fifo_mem[wr_ptr] <= gen_word;
    end

    // Flush overrides any push or pop in the same cycle.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (gen) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(gen) - LVL_W'(pop);
        end
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            ctrl_en   <= 1'b0;
            seed_q    <= DEFAULT_SEED;
            underflow <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl_en <= s00_axi_wdata[CTRL_EN];
            if (seed_wr) seed_q <= seed_new;
            // A new underflow in the same cycle as a clear stays visible.
            if (clr_uf)        underflow <= 1'b0;
            if (underflow_evt) underflow <= 1'b1;
        end
    end

`ifdef TRNG_IRQ_EN
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            irq_en <= 1'b0;
            thresh <= '0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= s00_axi_wdata[CTRL_IRQ_EN];
            if (wr_en && (widx == AIDX_W'(REG_THRESH)) && s00_axi_wstrb[0])
                thresh <= s00_axi_wdata[7:0];
            irq <= irq_en && (level8 >= thresh) && (thresh != '0);
        end
    end
`endif

    // NOTE: default assigned first so no path through the case infers a latch.
    always_comb begin
        rd_word = '0;
        case (ridx)
            AIDX_W'(REG_CTRL): begin
                rd_word[CTRL_EN] = ctrl_en;
`ifdef TRNG_IRQ_EN
                rd_word[CTRL_IRQ_EN] = irq_en;
`endif
            end
            AIDX_W'(REG_SEED): rd_word = seed_q;
            AIDX_W'(REG_STATUS): begin
                rd_word[7:0]            = level8;
                rd_word[STAT_EMPTY]     = empty;
                rd_word[STAT_FULL]      = full;
                rd_word[STAT_UNDERFLOW] = underflow;
            end
            AIDX_W'(REG_DATA): rd_word = empty ? '0 : fifo_mem[rd_ptr];
`ifdef TRNG_IRQ_EN
            AIDX_W'(REG_THRESH): rd_word[7:0] = thresh;
`endif
            default: rd_word = '0;
        endcase
    end

    // Write channel: ready pulses for one cycle, then B is held until taken.
    assign s00_axi_bresp = RESP_OKAY;

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
        end else begin
            s00_axi_awready <= s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid && !s00_axi_awready;
            s00_axi_wready  <= s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid && !s00_axi_awready;
            if (wr_en)               s00_axi_bvalid <= 1'b1;
            else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;
        end
    end

    // Read channel: data and response are captured on the AR accept cycle.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
        end else begin
            s00_axi_arready <= s00_axi_arvalid && !s00_axi_rvalid && !s00_axi_arready;
            if (rd_en) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_word;
                s00_axi_rresp  <= underflow_evt ? RESP_SLVERR : RESP_OKAY;
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trng_axil_fifo.sv
module tb_trng_axil_fifo;

    localparam int DEPTH = 8;
    localparam int LANES = 2;

    logic        clk = 1'b0;
    logic        areset;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
`ifdef TRNG_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    trng_axil_fifo dut (
`ifdef TRNG_IRQ_EN
        .irq            (irq),
`endif
        .s00_axi_aclk   (clk),
        .s00_axi_areset (areset),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_araddr (araddr),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_lane [LANES];
    logic [31:0] m_seed;
    logic [31:0] m_q [$];

    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h80200003;
        return n;
    endfunction

    task automatic m_set_lanes(input logic [31:0] s);
        for (int k = 0; k < LANES; k++) m_lane[k] = s ^ (32'(k) * 32'h9E3779B9);
    endtask

    task automatic m_load(input logic [31:0] v, input logic [3:0] strb);
        logic [31:0] merged;
        merged = m_seed;
        for (int b = 0; b < 4; b++) if (strb[b]) merged[8*b +: 8] = v[8*b +: 8];
        if (merged == 32'h0) merged = 32'hACE12024;
        m_seed = merged;
        m_set_lanes(merged);
    endtask

    // Enabled long enough to saturate: queue tops up to DEPTH words.
    task automatic m_fill();
        logic [31:0] w;
        while (m_q.size() < DEPTH) begin
            w = 32'h0;
            for (int k = 0; k < LANES; k++) begin
                m_lane[k] = m_step(m_lane[k]);
                w ^= m_lane[k];
            end
            m_q.push_back(w);
        end
    endtask

    task automatic m_reset();
        m_seed = 32'hACE12024;
        m_set_lanes(m_seed);
        m_q.delete();
    endtask

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int cyc;
        resp = 2'bxx;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!awready && cyc < 50);
        if (!awready) begin
            timeout_fail("aw_accept");
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        cyc = 0;
        while (!bvalid && cyc < 50) begin @(negedge clk); cyc++; end
        if (!bvalid) begin
            timeout_fail("b_valid");
            return;
        end
        resp = bresp;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        logic [1:0] r;
        axi_write(addr, data, 4'hF, r);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        data = 32'hxxxxxxxx;
        resp = 2'bxx;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!arready && cyc < 50);
        if (!arready) begin
            timeout_fail("ar_accept");
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 50) begin @(negedge clk); cyc++; end
        if (!rvalid) begin
            timeout_fail("r_valid");
            return;
        end
        data = rdata;
        resp = rresp;
        @(posedge clk); #1;
    endtask

    task automatic read_check(input string name, input logic [4:0] addr,
                              input logic [31:0] exp, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check(name, d, exp);
        check({name, "_resp"}, {30'h0, r}, {30'h0, exp_resp});
    endtask

    task automatic pop_check(input string name);
        logic [31:0] exp;
        if (m_q.size() == 0) exp = 32'h0;
        else                 exp = m_q.pop_front();
        read_check(name, 5'h0C, exp, 2'b00);
    endtask

    // ---------------- register table ----------------
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, s;
        logic [1:0]  r;
        logic [3:0]  strb;
        int          npop, cyc;

        areset = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 1;
        araddr = '0; arvalid = 0; rready = 1;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;
        m_reset();

        // Reset state of the bus outputs.
        @(negedge clk);
        check("rst_awready", {31'h0, awready}, 32'h0);
        check("rst_wready",  {31'h0, wready},  32'h0);
        check("rst_bvalid",  {31'h0, bvalid},  32'h0);
        check("rst_arready", {31'h0, arready}, 32'h0);
        check("rst_rvalid",  {31'h0, rvalid},  32'h0);
        check("rst_rdata",   rdata,            32'h0);
        check("rst_rresp",   {30'h0, rresp},   32'h0);
`ifdef TRNG_IRQ_EN
        check("rst_irq",     {31'h0, irq},     32'h0);
`endif
        read_check("rst_status", 5'h08, 32'h0001_0000, 2'b00);
        read_check("rst_ctrl",   5'h00, 32'h0,         2'b00);
        read_check("rst_seed",   5'h04, 32'hACE12024,  2'b00);
        read_check("rst_0x18",   5'h18, 32'h0,         2'b00);

        // Register write/readback vectors.
        vecs[0] = '{5'h04, 32'h12345678, 4'hF, 32'h12345678};
        vecs[1] = '{5'h04, 32'h00000000, 4'hF, 32'hACE12024};
        vecs[2] = '{5'h04, 32'hFFFFFFFF, 4'h1, 32'hACE120FF};
        vecs[3] = '{5'h04, 32'h00000000, 4'h0, 32'hACE120FF};
`ifdef TRNG_IRQ_EN
        vecs[4] = '{5'h10, 32'h00000005, 4'hF, 32'h00000005};
        vecs[7] = '{5'h00, 32'h0000000E, 4'hF, 32'h00000008};
`else
        vecs[4] = '{5'h10, 32'h00000005, 4'hF, 32'h00000000};
        vecs[7] = '{5'h00, 32'h0000000E, 4'hF, 32'h00000000};
`endif
        vecs[5] = '{5'h14, 32'hDEADBEEF, 4'hF, 32'h00000000};
        vecs[6] = '{5'h1C, 32'hDEADBEEF, 4'hF, 32'h00000000};
        vecs[8] = '{5'h00, 32'h00000001, 4'hF, 32'h00000001};
        vecs[9] = '{5'h00, 32'h00000000, 4'hF, 32'h00000000};

        for (int i = 0; i < 10; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, r);
            check($sformatf("vec%0d_bresp", i), {30'h0, r}, 32'h0);
            read_check($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp, 2'b00);
        end

        // Known seed, fill, pop, level reporting.
        wr(5'h00, 32'h2);
        wr(5'h04, 32'h1);
        m_load(32'h1, 4'hF);
        wr(5'h00, 32'h1);
        repeat (20) @(posedge clk);
        m_fill();
        read_check("status_full", 5'h08, 32'h0002_0008, 2'b00);
        pop_check("seed1_word0");
        pop_check("seed1_word1");
        m_fill();
        wr(5'h00, 32'h0);
        pop_check("seed1_word2");
        read_check("status_level7", 5'h08, 32'h0000_0007, 2'b00);

        // Underflow and clear.
        wr(5'h00, 32'h2);
        m_q.delete();
        read_check("underflow_data", 5'h0C, 32'h0, 2'b10);
        read_check("underflow_status", 5'h08, 32'h0005_0000, 2'b00);
        wr(5'h00, 32'h4);
        read_check("uf_cleared_status", 5'h08, 32'h0001_0000, 2'b00);

        // Randomised seeds, partial strobes, partial drains and refills.
        for (int it = 0; it < 4; it++) begin
            wr(5'h00, 32'h2);
            m_q.delete();
            s    = $urandom;
            strb = 4'($urandom_range(1, 15));
            axi_write(5'h04, s, strb, r);
            m_load(s, strb);
            read_check("rand_seed_rb", 5'h04, m_seed, 2'b00);
            wr(5'h00, 32'h1);
            repeat (DEPTH + 4) @(posedge clk);
            wr(5'h00, 32'h0);
            m_fill();
            npop = $urandom_range(1, DEPTH);
            for (int p = 0; p < npop; p++) pop_check("rand_pop_a");
            read_check("rand_status", 5'h08,
                       32'(DEPTH - npop) | ((npop == DEPTH) ? 32'h0001_0000 : 32'h0), 2'b00);
            wr(5'h00, 32'h1);
            repeat (DEPTH + 4) @(posedge clk);
            wr(5'h00, 32'h0);
            m_fill();
            for (int p = 0; p < DEPTH; p++) pop_check("rand_pop_b");
            read_check("rand_underflow", 5'h0C, 32'h0, 2'b10);
            wr(5'h00, 32'h4);
        end

        // Reset while filling with a read response outstanding.
        wr(5'h00, 32'h1);
        @(posedge clk); #1;
        araddr = 5'h08; arvalid = 1'b1; rready = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!arready && cyc < 50);
        if (!arready) timeout_fail("rst_ar_accept");
        @(posedge clk); #1;
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 50) begin @(negedge clk); cyc++; end
        check("pending_rvalid", {31'h0, rvalid}, 32'h1);
        @(negedge clk);
        areset = 1'b1;
        #1;
        check("async_rst_rvalid",  {31'h0, rvalid},  32'h0);
        check("async_rst_rdata",   rdata,            32'h0);
        check("async_rst_arready", {31'h0, arready}, 32'h0);
        @(posedge clk); #1;
        areset = 1'b0;
        rready = 1'b1;
        m_reset();
        read_check("post_rst_status", 5'h08, 32'h0001_0000, 2'b00);
        read_check("post_rst_seed",   5'h04, 32'hACE12024,  2'b00);
        read_check("post_rst_ctrl",   5'h00, 32'h0,         2'b00);

`ifdef TRNG_IRQ_EN
        wr(5'h10, 32'h4);
        wr(5'h00, 32'h9);
        cyc = 0;
        while (!irq && cyc < 10) begin @(negedge clk); cyc++; end
        check("irq_rise", {31'h0, irq}, 32'h1);
        wr(5'h00, 32'hA);
        cyc = 0;
        while (irq && cyc < 4) begin @(negedge clk); cyc++; end
        check("irq_fall_on_flush", {31'h0, irq}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
